// File: rtl/rr_bus_arbiter_4_pkg.sv
// Shared definitions for the 4-source round-robin bus arbiter.
// The mux select codes are shared with the downstream 4:1 datapath mux.
package rr_bus_arbiter_4_pkg;

    // Mux select codes, one per channel/source
    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;
    localparam logic [1:0] CH2 = 2'b10;
    localparam logic [1:0] CH3 = 2'b11;

    // Default ownership limits
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_CNT_W    = 4;

    // Arbiter FSM state codes (2-bit binary)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    // One-hot grant vector for a select code
    function automatic logic [3:0] sel_to_gnt(input logic [1:0] s);
        logic [3:0] g;
        g    = 4'b0000;
        g[s] = 1'b1;
        return g;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: returns the first requesting source found
// when scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4). Purely combinational.
module rr_priority_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] win,
    output logic       any
);

    logic [1:0] idx;

    // Scan from the farthest offset down to offset 0 so the closest
    // requester to ptr is the last (and therefore winning) assignment.
    always_comb begin
        win = ptr;
        any = 1'b0;
        idx = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter_4.sv
// Round-robin arbiter driving the 2-bit select of the 4:1 datapath mux.
// One owner at a time, select held stable for the whole ownership,
// forced release after MAX_HOLD grant cycles. All outputs are registered.
// MAX_HOLD must be >= 1 and fit in CNT_W bits (2**CNT_W >= MAX_HOLD).
//
// Handshake: a source asserts req[i] and keeps it high while it wants the
// bus; gnt[i] high means it owns the bus. Ownership ends on done, on the
// owner dropping req, or on the hold limit; gnt then stays low for at
// least two cycles (RELEASE + IDLE) before the next owner is granted.
import rr_bus_arbiter_4_pkg::*;

module rr_bus_arbiter_4 #(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             done,
    output logic [1:0]       sel,
    output logic [3:0]       gnt,
    output logic             bus_busy,
    output logic             timeout,
    output state_t           fsm_state,
    output logic [1:0]       ptr,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [1:0]       win;
    logic             any;
    logic             rel_done;
    logic             rel_drop;
    logic             rel_limit;

    rr_priority_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

    // Release causes; sel_q is the current owner while in GRANT
    assign rel_done  = done;
    assign rel_drop  = ~req[sel_q];
    assign rel_limit = (hold_q == HOLD_LAST);

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= CH0;
            gnt_q     <= 4'b0000;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'b00;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state and next-output logic; everything holds unless changed
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANT;
                    sel_d   = win;
                    gnt_d   = sel_to_gnt(win);
                    busy_d  = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = 4'b0000;
                    busy_d    = 1'b0;
                    ptr_d     = sel_q + 2'd1;
                    // Timeout flags only a release caused purely by the limit
                    timeout_d = rel_limit && !rel_done && !rel_drop;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign bus_busy  = busy_q;
    assign timeout   = timeout_q;
    assign fsm_state = state_q;
    assign ptr       = ptr_q;
    assign hold_cnt  = hold_q;

endmodule
